// File: rtl/rpi_accel_pkg.sv
// Shared definitions for the RPi instruction path and task_manager.
//   rx_state_t  : SPI frame receive FSM states
//   is_state_t  : instruction issue FSM states
//   STATUS_*    : bit positions inside the 8-bit status byte returned on MISO
//   OP_*        : opcode constants carried in RPi_inst[N-1:N-8]
package rpi_accel_pkg;

  typedef enum logic [1:0] {
    RX_WAIT_CS_HIGH,
    RX_IDLE,
    RX_SHIFT,
    RX_END
  } rx_state_t;

  typedef enum logic [1:0] {
    IS_IDLE,
    IS_REQ,
    IS_BUSY
  } is_state_t;

  localparam int unsigned STATUS_IDLE  = 7;
  localparam int unsigned STATUS_VALID = 6;
  localparam int unsigned STATUS_BUSY  = 5;
  localparam int unsigned STATUS_OVR   = 4;
  localparam int unsigned STATUS_FERR  = 3;
  localparam int unsigned STATUS_REJ   = 2;
  localparam int unsigned STATUS_TMO   = 1;

  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] OP_BGS  = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain.
//   clk, rst_n           : system clock, synchronous active-low reset
//   spi_sclk/cs_n/mosi   : raw SPI pins
//   cs_n, mosi           : synchronized levels, aligned with the edge pulses
//   sclk_rise/sclk_fall  : 1-cycle pulses on synchronized SCLK edges
//   cs_fall/cs_rise      : 1-cycle pulses on synchronized chip-select edges
// Pin edge to pulse latency is exactly 3 clk (2 sync stages + registered detect).
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic cs_n,
  output logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  // cs_n resets low so that a pin already high after reset only produces a
  // rise (ignored while waiting for CS high), never a spurious fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q    <= '0;
      cs_q      <= '0;
      mosi_q    <= '0;
      cs_n      <= 1'b0;
      mosi      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[1:0], spi_sclk};
      cs_q      <= {cs_q[1:0], spi_cs_n};
      mosi_q    <= {mosi_q[0], spi_mosi};
      cs_n      <= cs_q[1];
      mosi      <= mosi_q[1];
      sclk_rise <= sclk_q[1] & ~sclk_q[2];
      sclk_fall <= ~sclk_q[1] & sclk_q[2];
      cs_fall   <= ~cs_q[1] & cs_q[2];
      cs_rise   <= cs_q[1] & ~cs_q[2];
    end
  end

endmodule

// File: rtl/rpi_inst_receiver.sv
// SPI mode-0 slave that assembles one N-bit instruction per chip-select frame
// and hands it to task_manager through an execute_task request.
//   clk, rst_n             : system clock, synchronous active-low reset
//   spi_sclk/cs_n/mosi     : SPI pins from the RPi (asynchronous)
//   spi_miso               : status byte, MSB first, during the first 8 SCLKs
//   RPi_inst               : last accepted instruction, stable while requesting
//   execute_task           : request to task_manager
//   inst_valid, idle       : task_manager validity / idle feedback
//   frame_error, overrun   : 1-cycle event pulses
module rpi_inst_receiver
  import rpi_accel_pkg::*;
#(
  parameter int unsigned N          = 80,
  parameter int unsigned ACCEPT_TMO = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         spi_sclk,
  input  logic         spi_cs_n,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic [N-1:0] RPi_inst,
  output logic         execute_task,
  input  logic         inst_valid,
  input  logic         idle,
  output logic         frame_error,
  output logic         overrun
);

  localparam int unsigned CW = $clog2(N + 2);
  localparam int unsigned TW = $clog2(ACCEPT_TMO + 1);
  localparam logic [CW-1:0] BITS_FULL = CW'(N);
  localparam logic [CW-1:0] BITS_SAT  = CW'(N + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACCEPT_TMO - 1);

  logic cs_n_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .cs_n      (cs_n_s),
    .mosi      (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  rx_state_t rx_q, rx_d;
  is_state_t is_q, is_d;

  logic [N-1:0]  shreg_q, inst_q;
  logic [CW-1:0] bit_cnt_q;
  logic [7:0]    miso_sr_q;
  logic          miso_q;
  logic [TW-1:0] timer_q;
  logic          ovr_q, ferr_q, rej_q, tmo_q;
  logic          frame_error_q, overrun_q;

  logic       snap, start, end_err, end_ovr, set_rej, set_tmo;
  logic [7:0] status;

  assign status = {idle, inst_valid, (is_q != IS_IDLE), ovr_q, ferr_q, rej_q, tmo_q, 1'b0};

  // Receive FSM
  always_comb begin
    rx_d    = rx_q;
    snap    = 1'b0;
    start   = 1'b0;
    end_err = 1'b0;
    end_ovr = 1'b0;
    unique case (rx_q)
      RX_WAIT_CS_HIGH: if (cs_n_s) rx_d = RX_IDLE;
      RX_IDLE: begin
        if (cs_fall) begin
          snap = 1'b1;
          rx_d = RX_SHIFT;
        end
      end
      RX_SHIFT: if (cs_rise) rx_d = RX_END;
      RX_END: begin
        rx_d = RX_IDLE;
        if (bit_cnt_q != BITS_FULL) end_err = 1'b1;
        else if (is_q != IS_IDLE)   end_ovr = 1'b1;
        else                        start   = 1'b1;
      end
      default: rx_d = RX_WAIT_CS_HIGH;
    endcase
  end

  // Issue FSM; execute_task is a pure state decode so reset drops it next cycle.
  always_comb begin
    is_d         = is_q;
    set_rej      = 1'b0;
    set_tmo      = 1'b0;
    execute_task = (is_q == IS_REQ);
    unique case (is_q)
      IS_IDLE: if (start) is_d = IS_REQ;
      IS_REQ: begin
        if (timer_q == '0 && !inst_valid) begin
          set_rej = 1'b1;
          is_d    = IS_IDLE;
        end else if (!idle) begin
          is_d = IS_BUSY;
        end else if (timer_q == TMO_LAST) begin
          set_tmo = 1'b1;
          is_d    = IS_IDLE;
        end
      end
      IS_BUSY: if (idle) is_d = IS_IDLE;
      default: is_d = IS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q          <= RX_WAIT_CS_HIGH;
      is_q          <= IS_IDLE;
      inst_q        <= '0;
      timer_q       <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_q         <= 1'b0;
      ferr_q        <= 1'b0;
      rej_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      rx_q          <= rx_d;
      is_q          <= is_d;
      frame_error_q <= end_err;
      overrun_q     <= end_ovr;
      if (start) inst_q <= shreg_q;
      timer_q <= (is_q == IS_REQ) ? timer_q + TW'(1) : '0;
      // Sticky flags clear on the snapshot; a same-cycle set wins.
      ovr_q  <= end_ovr | (ovr_q & ~snap);
      ferr_q <= end_err | (ferr_q & ~snap);
      rej_q  <= set_rej | (rej_q & ~snap);
      tmo_q  <= set_tmo | (tmo_q & ~snap);
    end
  end

  // Frame datapath: MOSI shifter, bit counter and MISO status shifter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      miso_sr_q <= '0;
      miso_q    <= 1'b0;
    end else if (snap) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      miso_q    <= status[7];
      miso_sr_q <= {status[6:0], 1'b0};
    end else if (rx_q == RX_SHIFT) begin
      if (sclk_rise) begin
        shreg_q <= {shreg_q[N-2:0], mosi_s};
        if (bit_cnt_q != BITS_SAT) bit_cnt_q <= bit_cnt_q + CW'(1);
      end
      // Zeros fill in behind the status byte, so MISO is 0 after 8 bits.
      if (cs_rise) begin
        miso_q <= 1'b0;
      end else if (sclk_fall) begin
        miso_q    <= miso_sr_q[7];
        miso_sr_q <= {miso_sr_q[6:0], 1'b0};
      end
    end else begin
      miso_q <= 1'b0;
    end
  end

  assign spi_miso    = miso_q;
  assign RPi_inst    = inst_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule
